mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Arbitrates the single shared memory port between the fetch stage (instruction reads) and the MEM stage (loads/stores) of the five-stage pipeline. Generates the pipeline-register enables and the F/D bubble control. Holds one fetched instruction in a buffer so a fetch that completes during a back-end stall is not lost. Discards in-flight fetches on a redirect (flush driven from the W-stage PCSrc).

Parameters:
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
f_req  in  1  fetch stage requests instruction at f_addr
f_addr  in  AW  fetch address (current PC)
f_valid  out  1  instruction available on f_instr this cycle
f_instr  out  DW  instruction word
m_req  in  1  MEM stage has a load/store; held high until m_done
m_we  in  1  1 = store, 0 = load
m_addr  in  AW  data address
m_wdata  in  DW  store data
m_done  out  1  data access completes this cycle
m_rdata  out  DW  load data, valid when m_done
flush  in  1  redirect; invalidate buffered/in-flight fetch
en_pipe  out  1  enable for PC, F/D, D/E, E/M, M/W registers
en_pc  out  1  PC update enable
clr_fd  out  1  load bubble into F/D
bus_req  out  1  memory request, held until bus_ack
bus_we  out  1  memory write
bus_addr  out  AW  memory address
bus_wdata  out  DW  memory write data
bus_ack  in  1  memory completes; may assert in any cycle bus_req=1, including the first
bus_rdata  in  DW  memory read data, valid with bus_ack

Behaviour:
- Reset: state IDLE; bus_req, bus_we, ibuf_valid and drop are 0; bus_addr, bus_wdata and ibuf are 0. Outputs follow from these. Reset mid-access abandons the transaction with no completion pulse.
- States: IDLE, FETCH, DATA. Bus outputs are registered and latched at issue; they stay stable while bus_req=1.
- IDLE:
  - m_req=1: go to DATA, bus_we=m_we, bus_addr=m_addr, bus_wdata=m_wdata. Data access has priority over fetch.
  - Otherwise f_req=1 and the buffer is empty (or consumed this cycle) and flush=0: go to FETCH with bus_we=0 and bus_addr=f_addr.
- FETCH, on bus_ack:
  - If drop=0 and flush=0, the instruction goes to ibuf and ibuf_valid=1.
  - Next state is DATA if m_req=1 (issued the same cycle), else IDLE.
  - A fetch is never aborted on the bus.
- DATA, on bus_ack: m_done=1 combinationally, m_rdata=bus_rdata; next state IDLE.
- Minimum access latency: 1 cycle issue plus ack. A sustained fetch stream yields one instruction per 2 cycles with a zero-wait memory.
- Combinational outputs:
  - f_valid = ibuf_valid.
  - f_instr = ibuf.
  - en_pipe = !m_req | m_done.
  - en_pc = en_pipe & f_valid.
  - clr_fd = en_pipe & !f_valid.
- Buffer: ibuf_valid is cleared when consumed (en_pc=1) or when flush=1. A fill and a consume in the same cycle cannot occur, because the fill lands on the next edge.
- Flush:
  - Flush in FETCH before the ack sets drop=1. The ack clears drop and discards the data.
  - Flush in the ack cycle discards the data.
  - Flush in DATA has no effect on the data access.
  - Flush does not stall the pipeline.
- Simultaneous m_req and f_req in IDLE: DATA wins. The fetch is issued after the data access completes.
- The cycle m_done=1 is also the advance cycle, so the next m_req seen belongs to a new instruction. No re-serve guard is needed.

Decomposition:
- Shared package: state encoding (ARB_IDLE, ARB_FETCH, ARB_DATA) and the AW/DW defaults.
- Natural sub-module: fetch_buf (ibuf, ibuf_valid, drop, and the flush/consume logic).
- The FSM and bus registers stay in the top.

Test Plan:
- Reset, then f_req=1, f_addr=0x100, memory acks on the first bus_req cycle. Expect bus_req in cycle 1 with addr 0x100, f_valid=1 in cycle 2 with f_instr=rdata, en_pc=1.
- m_req=1 load at 0x2000 together with f_req in IDLE, memory ack delayed 3 cycles. Expect DATA first, en_pipe=0 for 3 cycles, then m_done=1 and m_rdata=0xDEADBEEF with en_pipe=1, then the fetch is issued.
- Fetch in flight with ack at cycle 4 and flush at cycle 2. Expect f_valid to stay 0, ibuf not loaded, clr_fd=1, and the next fetch to use the new f_addr.
- Fetch completes while m_req is stalling. Expect the instruction held in ibuf (f_valid=1, en_pc=0) until m_done, then consumed.
- Store m_we=1, addr 0x40, wdata 0x55. Expect bus_we=1, bus_wdata=0x55 stable until ack, then m_done=1.
- Assert reset during DATA with ack pending. Expect bus_req=0 immediately, state IDLE, no m_done.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/MEM memory-port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned ARB_AW = 32;
  localparam int unsigned ARB_DW = 32;

  // Owner of the shared bus: nobody, the fetch stage, or the MEM stage.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_FETCH = 2'd1,
    ARB_DATA  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_fetch_buf.sv
// One-entry instruction buffer. Catches a fetch that completes while the back
// end is stalled, and discards fetches that a redirect has made stale.
module mem_port_arbiter_fetch_buf #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_fetch,   // bus currently owned by a fetch
  input  logic          ack,
  input  logic [DW-1:0] rdata,
  input  logic          flush,
  input  logic          consume,    // F/D takes the buffered instruction
  output logic          ibuf_valid,
  output logic [DW-1:0] ibuf
);

  logic          drop_q, drop_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] ibuf_q, ibuf_d;

  // Buffer state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_q  <= 1'b0;
      valid_q <= 1'b0;
      ibuf_q  <= '0;
    end else begin
      drop_q  <= drop_d;
      valid_q <= valid_d;
      ibuf_q  <= ibuf_d;
    end
  end

  // Drop marks a fetch made stale by an earlier flush; it lives until that fetch acks.
  always_comb begin
    drop_d  = drop_q;
    valid_d = valid_q;
    ibuf_d  = ibuf_q;
    if (in_fetch) begin
      if (ack) begin
        drop_d = 1'b0;
      end else if (flush) begin
        drop_d = 1'b1;
      end
    end
    if (consume || flush) begin
      valid_d = 1'b0;
    end
    // A fill only happens in FETCH, when the buffer is already free.
    if (in_fetch && ack && !drop_q && !flush) begin
      valid_d = 1'b1;
      ibuf_d  = rdata;
    end
  end

  assign ibuf_valid = valid_q;
  assign ibuf       = ibuf_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and MEM-stage
// loads/stores, and produces the pipeline enables and F/D bubble control.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW = ARB_AW,
  parameter int unsigned DW = ARB_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_valid,
  output logic [DW-1:0] f_instr,
  input  logic          m_req,
  input  logic          m_we,
  input  logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_wdata,
  output logic          m_done,
  output logic [DW-1:0] m_rdata,
  input  logic          flush,
  output logic          en_pipe,
  output logic          en_pc,
  output logic          clr_fd,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata
);

  arb_state_e    state_q, state_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;

  logic          ibuf_valid;
  logic [DW-1:0] ibuf;
  logic          buf_free;

  mem_port_arbiter_fetch_buf #(
    .DW (DW)
  ) u_fetch_buf (
    .clk        (clk),
    .reset      (reset),
    .in_fetch   (state_q == ARB_FETCH),
    .ack        (bus_ack),
    .rdata      (bus_rdata),
    .flush      (flush),
    .consume    (en_pc),
    .ibuf_valid (ibuf_valid),
    .ibuf       (ibuf)
  );

  // A new fetch may issue if the buffer is empty or is being consumed now.
  assign buf_free = !ibuf_valid || en_pc;

  // FSM state and registered bus request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  // Next state; bus fields are latched only at issue so they hold while bus_req=1.
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (m_req) begin
          state_d     = ARB_DATA;
          bus_req_d   = 1'b1;
          bus_we_d    = m_we;
          bus_addr_d  = m_addr;
          bus_wdata_d = m_wdata;
        end else if (f_req && buf_free && !flush) begin
          state_d    = ARB_FETCH;
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = f_addr;
        end
      end
      ARB_FETCH: begin
        // Fetches always run to completion; a waiting data access follows back-to-back.
        if (bus_ack) begin
          if (m_req) begin
            state_d     = ARB_DATA;
            bus_req_d   = 1'b1;
            bus_we_d    = m_we;
            bus_addr_d  = m_addr;
            bus_wdata_d = m_wdata;
          end else begin
            state_d   = ARB_IDLE;
            bus_req_d = 1'b0;
          end
        end
      end
      ARB_DATA: begin
        if (bus_ack) begin
          state_d   = ARB_IDLE;
          bus_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = ARB_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // Completion and pipeline control; m_done doubles as the advance cycle.
  always_comb begin
    m_done  = (state_q == ARB_DATA) && bus_ack;
    m_rdata = bus_rdata;
    f_valid = ibuf_valid;
    f_instr = ibuf;
    en_pipe = !m_req || m_done;
    en_pc   = en_pipe && ibuf_valid;
    clr_fd  = en_pipe && !ibuf_valid;
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-programmable memory model
// and scoreboards for delivered instructions and completed data accesses.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_valid;
  logic [31:0] f_instr;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_done;
  logic [31:0] m_rdata;
  logic        flush;
  logic        en_pipe;
  logic        en_pc;
  logic        clr_fd;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          looked = 1'b0;

  typedef struct packed {
    logic        we;
    logic [31:0] data;
  } dexp_t;

  logic [31:0] f_q[$];
  dexp_t       d_q[$];

  int unsigned wait_cnt;
  int unsigned ack_delay;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW (32),
    .DW (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_valid   (f_valid),
    .f_instr   (f_instr),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_done    (m_done),
    .m_rdata   (m_rdata),
    .flush     (flush),
    .en_pipe   (en_pipe),
    .en_pc     (en_pc),
    .clr_fd    (clr_fd),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h2000) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'hC3C3, a[15:0] ^ 16'h1234};
  endfunction

  // Memory: acks once bus_req has been waiting ack_delay cycles (0 = same cycle).
  assign bus_ack   = bus_req && (wait_cnt >= ack_delay);
  assign bus_rdata = mem_word(bus_addr);

  always @(posedge clk or posedge reset) begin
    if (reset) wait_cnt <= 0;
    else if (!bus_req || bus_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Settle, then retire whatever the DUT delivers this cycle against the scoreboards.
  task automatic look();
    logic [31:0] e;
    dexp_t       d;
    #2;
    if (en_pc === 1'b1) begin
      checks++;
      assert (f_q.size() > 0)
      else begin
        errors++;
        $error("FAIL sb_instr_unexpected: observed f_instr=%h expected no instruction", f_instr);
      end
      if (f_q.size() > 0) begin
        e = f_q.pop_front();
        check("sb_instr", f_instr, e);
      end
    end
    if (m_done === 1'b1) begin
      checks++;
      assert (d_q.size() > 0)
      else begin
        errors++;
        $error("FAIL sb_done_unexpected: observed m_done=1 expected no completion");
      end
      if (d_q.size() > 0) begin
        d = d_q.pop_front();
        check("sb_we", {31'd0, bus_we}, {31'd0, d.we});
        if (d.we) check("sb_store_wdata", bus_wdata, d.data);
        else check("sb_load_rdata", m_rdata, d.data);
      end
    end
    looked = 1'b1;
  endtask

  task automatic adv();
    if (!looked) look();
    @(posedge clk);
    #1;
    looked = 1'b0;
  endtask

  initial begin
    reset = 1'b1; f_req = 1'b0; f_addr = '0; m_req = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; flush = 1'b0; ack_delay = 0;

    // Reset state
    @(posedge clk);
    #1;
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_we", bus_we, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_f_valid", f_valid, 0);
    check("rst_f_instr", f_instr, 0);
    check("rst_m_done", m_done, 0);
    check("rst_en_pipe", en_pipe, 1);
    check("rst_en_pc", en_pc, 0);
    check("rst_clr_fd", clr_fd, 1);
    reset = 1'b0;

    // Zero-wait fetch: issue next cycle, instruction one cycle later
    f_req = 1'b1; f_addr = 32'h100; f_q.push_back(mem_word(32'h100));
    look(); check("t1_idle_no_req", bus_req, 0);
    adv(); f_req = 1'b0; look();
    check("t1_bus_req", bus_req, 1);
    check("t1_bus_addr", bus_addr, 32'h100);
    check("t1_bus_we", bus_we, 0);
    adv(); look();
    check("t1_f_valid", f_valid, 1);
    check("t1_f_instr", f_instr, mem_word(32'h100));
    check("t1_en_pc", en_pc, 1);
    adv(); look(); check("t1_consumed", f_valid, 0);
    adv();

    // Sustained stream: one instruction every two cycles
    f_req = 1'b1; f_addr = 32'h180; f_q.push_back(mem_word(32'h180));
    adv();
    adv(); f_addr = 32'h184; f_q.push_back(mem_word(32'h184)); look();
    check("ts_first_valid", f_valid, 1);
    adv(); f_req = 1'b0; look(); check("ts_second_addr", bus_addr, 32'h184);
    adv(); look(); check("ts_second_valid", f_valid, 1);
    adv();

    // Load and fetch together: data wins, fetch follows
    ack_delay = 3; m_req = 1'b1; m_we = 1'b0; m_addr = 32'h2000; f_req = 1'b1; f_addr = 32'h104;
    d_q.push_back('{we: 1'b0, data: 32'hDEAD_BEEF});
    f_q.push_back(mem_word(32'h104));
    look(); check("t2_en_pipe_req", en_pipe, 0);
    adv(); look();
    check("t2_bus_req", bus_req, 1);
    check("t2_data_first", bus_addr, 32'h2000);
    check("t2_bus_we", bus_we, 0);
    check("t2_stall0", en_pipe, 0);
    for (int i = 0; i < 2; i++) begin
      adv(); look();
      check("t2_stall", en_pipe, 0);
      check("t2_no_done", m_done, 0);
    end
    adv(); look();
    check("t2_m_done", m_done, 1);
    check("t2_m_rdata", m_rdata, 32'hDEAD_BEEF);
    check("t2_en_pipe_done", en_pipe, 1);
    adv(); m_req = 1'b0; look();
    check("t2_idle", bus_req, 0);
    check("t2_clr_fd", clr_fd, 1);
    adv(); f_req = 1'b0; ack_delay = 0; look();
    check("t2_fetch_req", bus_req, 1);
    check("t2_fetch_addr", bus_addr, 32'h104);
    check("t2_fetch_we", bus_we, 0);
    adv(); look(); check("t2_fetch_valid", f_valid, 1);
    adv();

    // Flush before the ack drops the in-flight fetch
    ack_delay = 3; f_req = 1'b1; f_addr = 32'h200;
    adv(); f_req = 1'b0; look(); check("t3_issued", bus_req, 1);
    adv(); flush = 1'b1; look();
    check("t3_no_abort", bus_req, 1);
    check("t3_no_stall", en_pipe, 1);
    adv(); flush = 1'b0; look(); check("t3_bubble", clr_fd, 1);
    adv(); look(); check("t3_ack_cycle", f_valid, 0);
    adv(); f_req = 1'b1; f_addr = 32'h300; ack_delay = 0; f_q.push_back(mem_word(32'h300)); look();
    check("t3_dropped", f_valid, 0);
    check("t3_idle", bus_req, 0);
    adv(); f_req = 1'b0; look(); check("t3_new_addr", bus_addr, 32'h300);
    adv(); look(); check("t3_new_instr", f_instr, mem_word(32'h300));
    adv();

    // Flush in the ack cycle discards the data
    f_req = 1'b1; f_addr = 32'h400;
    adv(); f_req = 1'b0; flush = 1'b1; look(); check("t3b_req", bus_req, 1);
    adv(); flush = 1'b0; look(); check("t3b_dropped", f_valid, 0);
    adv();

    // Fetch completes under a data stall; held until m_done
    ack_delay = 1; f_req = 1'b1; f_addr = 32'h500; f_q.push_back(mem_word(32'h500));
    adv(); f_req = 1'b0; m_req = 1'b1; m_we = 1'b0; m_addr = 32'h3000;
    d_q.push_back('{we: 1'b0, data: mem_word(32'h3000)});
    look();
    check("t4_stall", en_pipe, 0);
    check("t4_fetch_addr", bus_addr, 32'h500);
    adv(); look(); check("t4_fill_next_edge", f_valid, 0);
    adv(); look();
    check("t4_data_addr", bus_addr, 32'h3000);
    check("t4_held_valid", f_valid, 1);
    check("t4_held_no_pc", en_pc, 0);
    check("t4_held_instr", f_instr, mem_word(32'h500));
    adv(); look();
    check("t4_m_done", m_done, 1);
    check("t4_consume", en_pc, 1);
    adv(); m_req = 1'b0; look(); check("t4_empty", f_valid, 0);
    adv();

    // Store: bus fields latched at issue and stable until ack
    ack_delay = 2; m_req = 1'b1; m_we = 1'b1; m_addr = 32'h40; m_wdata = 32'h55;
    d_q.push_back('{we: 1'b1, data: 32'h55});
    adv(); look();
    check("t5_bus_we", bus_we, 1);
    check("t5_bus_addr", bus_addr, 32'h40);
    check("t5_bus_wdata", bus_wdata, 32'h55);
    check("t5_no_done", m_done, 0);
    adv(); m_addr = 32'h44; m_wdata = 32'hAA; look();
    check("t5_stable_addr", bus_addr, 32'h40);
    check("t5_stable_wdata", bus_wdata, 32'h55);
    adv(); look(); check("t5_m_done", m_done, 1);
    adv(); m_req = 1'b0; m_we = 1'b0; look(); check("t5_idle", bus_req, 0);
    adv();

    // Reset during a pending data access
    ack_delay = 5; m_req = 1'b1; m_we = 1'b0; m_addr = 32'h6000;
    adv(); look(); check("t6_req", bus_req, 1);
    adv(); look();
    reset = 1'b1;
    #1;
    check("t6_req_dropped", bus_req, 0);
    check("t6_addr_cleared", bus_addr, 0);
    check("t6_no_done", m_done, 0);
    m_req = 1'b0;
    adv(); reset = 1'b0; look();
    check("t6_idle_req", bus_req, 0);
    check("t6_idle_valid", f_valid, 0);
    adv(); look(); check("t6_still_idle", bus_req, 0);
    adv();

    check("sb_fetch_drained", 32'(f_q.size()), 0);
    check("sb_data_drained", 32'(d_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
